npu_seq_ctrl: RTL and testbench
===============================

Name: npu_seq_ctrl

Overview:
- Sequencer that drives npu_simple through one tile operation: bias load, weight load, input load, then a read/compute sweep.
- Consumes a 72-bit valid/ready load stream from the DMA side.
- Generates the write and read ports of npu_simple, and latches the post-processing configuration at start.
- Sits between the host command interface and npu_simple. It replaces bench-driven sequencing.

Parameters:
- WIDTH, 80, row-buffer width in entries; bias column index.
- HEIGHT, 8, number of rows/PEs (rows 0..HEIGHT-1).
- WIDTH_B, 7, column address width.
- HEIGHT_B, 3, row address width.
- IN_GROUPS, 8, 9-lane input groups per row.
- LAST_MASK, 9'h1FE, en_in lane mask for the last input group of a row.
- RD_GROUPS, 8, 9-lane read groups per row in the compute sweep.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a tile when idle.
- abort  in  1  synchronous; returns to IDLE.
- cfg_bound_level  in  3  latched at start.
- cfg_step_p  in  3  latched at start.
- cfg_relu  in  1  latched at start.
- cfg_mp  in  1  latched at start.
- s_valid  in  1  load stream beat valid.
- s_data  in  72  load stream beat; bias beats use [15:0].
- s_ready  out  1  controller accepts beat.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  1-cycle pulse at tile completion.
- write_w  out  WIDTH_B  write column.
- write_h  out  HEIGHT_B  write row.
- data_in  out  72  write data.
- en_in  out  9  per-lane write enables.
- readi_w  out  9*WIDTH_B  packed read columns; lane 0 in the MSBs.
- readi_h  out  9*HEIGHT_B  packed read rows.
- en_read  out  9  read lane enables.
- en_bias  out  1  bias read enable.
- step  out  3  current read group [2:0].
- en_pe  out  1  PE enable.
- bound_level, step_p  out  3 each  from the latched cfg.
- en_relu, en_mp  out  1 each  from the latched cfg.

Behaviour:
- Reset (async, reset=0): FSM goes to IDLE; all outputs and counters are 0.
- States: IDLE -> BIAS -> WGT -> INP -> RD -> DONE -> IDLE.
- IDLE:
  - start=1 latches cfg and enters BIAS with the row counter h=0.
  - start is ignored in every other state.
- Load states (BIAS, WGT, INP):
  - s_ready=1 exactly when the FSM is in a load state and abort=0.
  - An accepted beat (s_valid&s_ready) drives the write outputs on the next cycle for exactly one cycle.
  - en_in=0 in any cycle with no beat pending. Stalls on s_valid are unlimited.
- BIAS:
  - Per beat: write_w=WIDTH, write_h=h, data_in={s_data[15:0],56'b0}, en_in=9'h180.
  - After HEIGHT beats, go to WGT with h=0.
- WGT:
  - Per beat: write_w=WIDTH-9, write_h=h, data_in=s_data, en_in=9'h1FF.
  - After HEIGHT beats, go to INP.
- INP:
  - Nested counters: row j (outer), group g (inner).
  - Per beat: write_w=g*9, write_h=j, data_in=s_data.
  - en_in=LAST_MASK when g==IN_GROUPS-1, else 9'h1FF.
  - After HEIGHT*IN_GROUPS beats, go to RD.
- RD:
  - One read beat per cycle; no stall. Counters: row r (outer), group c (inner).
  - Lane k: readi_w = c*9+k, readi_h = r.
  - en_read=9'h1FF, en_bias=1, en_pe=1, step=c[2:0].
  - The first read beat appears the cycle after the last write pulse.
  - After HEIGHT*RD_GROUPS beats, go to DONE. Read outputs return to 0 in DONE.
- DONE: done=1 for one cycle; busy drops in the same cycle; next state IDLE.
- Config outputs hold their latched values until the next start.
- Address arithmetic is unsigned, truncated to WIDTH_B / HEIGHT_B. No wrap occurs with the defaults.
- abort=1 in any state:
  - Next cycle is IDLE; all enables are 0; busy=0; no done.
  - A beat presented in the abort cycle is not accepted.
  - abort has priority over start.
- Reset mid-tile: immediate return to IDLE and all outputs 0. No partial-write completion.
- Total tile length with no stalls: 16+64 load beats, then 64 read cycles, then 1 DONE cycle.

Decomposition:
- Shared package npu_pkg holds:
  - the state encoding;
  - lane-mask constants EN_ALL=9'h1FF, EN_BIAS=9'h180;
  - default geometry constants.
- One natural sub-module, npu_addr_cnt: a two-level (outer/inner) counter with wrap flags. It is instantiated once and reused for the BIAS/WGT/INP/RD sweeps.

Test Plan:
- Reset, then start with s_valid held high:
  - 8 bias writes at write_w=80, write_h=0..7, en_in=0x180, data_in[71:56]=bias[h];
  - then 8 weight writes at write_w=71, en_in=0x1FF.
- Input phase for row 3, groups 0..7:
  - write_w = 0,9,…,63 with write_h=3;
  - en_in=0x1FF for groups 0..6 and 0x1FE for group 7.
- Read sweep, beat r=2, c=1:
  - readi_w lanes = 9..17, readi_h lanes = 2;
  - step=1, en_read=0x1FF, en_pe=1, en_bias=1;
  - done pulses once, the cycle after beat 64.
- s_valid toggled every other cycle:
  - en_in pulses only after accepted beats;
  - addresses never skip;
  - total write pulses = 80.
- abort asserted during INP (row 4, group 2):
  - next cycle IDLE, s_ready=0, en_in=0, busy=0, no done;
  - a new start reloads from bias row 0.
- reset driven low mid-RD:
  - all outputs 0 immediately (asynchronously);
  - start pulses while busy are ignored (no counter restart).

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and constants for the npu_simple tile sequencer.
// State encoding, lane masks, default geometry and the latched post-processing config.
package npu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_BIAS = 3'd1,
      ST_WGT  = 3'd2,
      ST_INP  = 3'd3,
      ST_RD   = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam int LANES  = 9;
   localparam int DATA_W = 72;
   localparam int GRP_B  = 3;

   localparam logic [LANES-1:0] EN_ALL  = 9'h1FF;
   localparam logic [LANES-1:0] EN_BIAS = 9'h180;

   localparam int DEF_WIDTH     = 80;
   localparam int DEF_HEIGHT    = 8;
   localparam int DEF_WIDTH_B   = 7;
   localparam int DEF_HEIGHT_B  = 3;
   localparam int DEF_IN_GROUPS = 8;
   localparam int DEF_RD_GROUPS = 8;
   localparam logic [LANES-1:0] DEF_LAST_MASK = 9'h1FE;

   typedef struct packed {
      logic [2:0] bound_level;
      logic [2:0] step_p;
      logic       relu;
      logic       mp;
   } cfg_t;

endpackage

// File: rtl/npu_addr_cnt.sv
// Two-level row/group counter: one step per inc, wraps to zero after the last step; clr has priority.
// Count updates on the cycle after inc; no backpressure, the caller gates inc.
module npu_addr_cnt #(
   parameter int OW = 3,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   input  logic [OW-1:0] outer_max,
   input  logic [IW-1:0] inner_max,
   output logic [OW-1:0] outer,
   output logic [IW-1:0] inner,
   output logic          last
);

   logic inner_wrap;
   logic outer_wrap;

   assign inner_wrap = (inner == inner_max);
   assign outer_wrap = (outer == outer_max);
   assign last       = inner_wrap && outer_wrap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outer <= '0;
         inner <= '0;
      end else if (clr) begin
         outer <= '0;
         inner <= '0;
      end else if (inc) begin
         if (inner_wrap) begin
            inner <= '0;
            outer <= outer_wrap ? '0 : outer + OW'(1);
         end else begin
            inner <= inner + IW'(1);
         end
      end
   end

endmodule

// File: rtl/npu_seq_ctrl.sv
// Sequences one npu_simple tile (bias, weight, input loads, then read sweep); outputs registered, one cycle after accept.
// Load beats stall freely on s_valid; the read sweep never stalls; abort returns to idle on the next cycle.
module npu_seq_ctrl
   import npu_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               HEIGHT    = DEF_HEIGHT,
   parameter int               WIDTH_B   = DEF_WIDTH_B,
   parameter int               HEIGHT_B  = DEF_HEIGHT_B,
   parameter int               IN_GROUPS = DEF_IN_GROUPS,
   parameter logic [LANES-1:0] LAST_MASK = DEF_LAST_MASK,
   parameter int               RD_GROUPS = DEF_RD_GROUPS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic [2:0]                  cfg_bound_level,
   input  logic [2:0]                  cfg_step_p,
   input  logic                        cfg_relu,
   input  logic                        cfg_mp,
   input  logic                        s_valid,
   input  logic [DATA_W-1:0]           s_data,
   output logic                        s_ready,
   output logic                        busy,
   output logic                        done,
   output logic [WIDTH_B-1:0]          write_w,
   output logic [HEIGHT_B-1:0]         write_h,
   output logic [DATA_W-1:0]           data_in,
   output logic [LANES-1:0]            en_in,
   output logic [LANES*WIDTH_B-1:0]    readi_w,
   output logic [LANES*HEIGHT_B-1:0]   readi_h,
   output logic [LANES-1:0]            en_read,
   output logic                        en_bias,
   output logic [2:0]                  step,
   output logic                        en_pe,
   output logic [2:0]                  bound_level,
   output logic [2:0]                  step_p,
   output logic                        en_relu,
   output logic                        en_mp
);

   state_t state, state_nxt;
   cfg_t   cfg_q;

   logic load_st, accept, start_ok, rd_go;
   logic cnt_clr, cnt_inc, cnt_last;
   logic [HEIGHT_B-1:0] row;
   logic [GRP_B-1:0]    grp, grp_max;

   logic [WIDTH_B-1:0]        wr_w_nxt;
   logic [HEIGHT_B-1:0]       wr_h_nxt;
   logic [DATA_W-1:0]         wr_d_nxt;
   logic [LANES-1:0]          wr_en_nxt;
   logic [LANES*WIDTH_B-1:0]  rd_w_nxt;
   logic [LANES*HEIGHT_B-1:0] rd_h_nxt;

   function automatic logic [WIDTH_B-1:0] col_of(input logic [GRP_B-1:0] g, input int k);
      return WIDTH_B'(g) * WIDTH_B'(LANES) + WIDTH_B'(k);
   endfunction

   assign load_st  = (state == ST_BIAS) || (state == ST_WGT) || (state == ST_INP);
   assign s_ready  = load_st && !abort;
   assign accept   = s_valid && s_ready;
   assign start_ok = (state == ST_IDLE) && start && !abort;
   assign rd_go    = (state == ST_RD) && !abort;

   // One counter serves every sweep: held at zero while idle, and it wraps to zero
   // on its last step, so each phase hand-off starts from row 0 / group 0.
   assign cnt_clr = abort || (state == ST_IDLE);
   assign cnt_inc = accept || rd_go;
   assign grp_max = (state == ST_INP) ? GRP_B'(IN_GROUPS - 1) :
                    (state == ST_RD)  ? GRP_B'(RD_GROUPS - 1) : '0;

   npu_addr_cnt #(
      .OW (HEIGHT_B),
      .IW (GRP_B)
   ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (cnt_clr),
      .inc       (cnt_inc),
      .outer_max (HEIGHT_B'(HEIGHT - 1)),
      .inner_max (grp_max),
      .outer     (row),
      .inner     (grp),
      .last      (cnt_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_ok) state_nxt = ST_BIAS;
         ST_BIAS: if (accept && cnt_last) state_nxt = ST_WGT;
         ST_WGT:  if (accept && cnt_last) state_nxt = ST_INP;
         ST_INP:  if (accept && cnt_last) state_nxt = ST_RD;
         ST_RD:   if (cnt_last) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   always_comb begin
      wr_w_nxt  = '0;
      wr_h_nxt  = '0;
      wr_d_nxt  = '0;
      wr_en_nxt = '0;
      if (accept) begin
         wr_h_nxt  = row;
         wr_d_nxt  = s_data;
         wr_en_nxt = EN_ALL;
         case (state)
            ST_BIAS: begin
               wr_w_nxt  = WIDTH_B'(WIDTH);
               wr_d_nxt  = {s_data[15:0], {(DATA_W-16){1'b0}}};
               wr_en_nxt = EN_BIAS;
            end
            ST_WGT: wr_w_nxt = WIDTH_B'(WIDTH - LANES);
            ST_INP: begin
               wr_w_nxt = col_of(grp, 0);
               if (grp == GRP_B'(IN_GROUPS - 1)) wr_en_nxt = LAST_MASK;
            end
            default: wr_en_nxt = '0;
         endcase
      end
   end

   // Lane 0 occupies the most significant slice of the packed read buses.
   always_comb begin
      rd_w_nxt = '0;
      rd_h_nxt = '0;
      if (rd_go) begin
         for (int k = 0; k < LANES; k++) begin
            rd_w_nxt[(LANES-1-k)*WIDTH_B +: WIDTH_B]   = col_of(grp, k);
            rd_h_nxt[(LANES-1-k)*HEIGHT_B +: HEIGHT_B] = row;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_w <= '0;
         write_h <= '0;
         data_in <= '0;
         en_in   <= '0;
         readi_w <= '0;
         readi_h <= '0;
         en_read <= '0;
         en_bias <= 1'b0;
         en_pe   <= 1'b0;
         step    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         cfg_q   <= '0;
      end else begin
         write_w <= wr_w_nxt;
         write_h <= wr_h_nxt;
         data_in <= wr_d_nxt;
         en_in   <= wr_en_nxt;
         readi_w <= rd_w_nxt;
         readi_h <= rd_h_nxt;
         en_read <= rd_go ? EN_ALL : '0;
         en_bias <= rd_go;
         en_pe   <= rd_go;
         step    <= rd_go ? 3'(grp) : 3'd0;
         busy    <= (state_nxt != ST_IDLE);
         done    <= (state == ST_DONE) && !abort;
         if (start_ok) begin
            cfg_q <= '{bound_level: cfg_bound_level, step_p: cfg_step_p,
                       relu: cfg_relu, mp: cfg_mp};
         end
      end
   end

   assign bound_level = cfg_q.bound_level;
   assign step_p      = cfg_q.step_p;
   assign en_relu     = cfg_q.relu;
   assign en_mp       = cfg_q.mp;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Bench for npu_seq_ctrl: write/read scoreboard sampled 1 time unit after each rising edge,
// literal vector table for key load addresses, hand sequences for abort and async reset.
module tb_npu_seq_ctrl;
   import npu_pkg::*;

   logic        clk, reset, start, abort;
   logic [2:0]  cfg_bound_level, cfg_step_p;
   logic        cfg_relu, cfg_mp, s_valid, s_ready, busy, done;
   logic [71:0] s_data, data_in;
   logic [6:0]  write_w;
   logic [2:0]  write_h, step, bound_level, step_p;
   logic [8:0]  en_in, en_read;
   logic [62:0] readi_w;
   logic [26:0] readi_h;
   logic        en_bias, en_pe, en_relu, en_mp;

   npu_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_bound_level(cfg_bound_level), .cfg_step_p(cfg_step_p),
      .cfg_relu(cfg_relu), .cfg_mp(cfg_mp),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .busy(busy), .done(done),
      .write_w(write_w), .write_h(write_h), .data_in(data_in), .en_in(en_in),
      .readi_w(readi_w), .readi_h(readi_h), .en_read(en_read), .en_bias(en_bias),
      .step(step), .en_pe(en_pe), .bound_level(bound_level), .step_p(step_p),
      .en_relu(en_relu), .en_mp(en_mp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  w;
      logic [2:0]  h;
      logic [71:0] d;
      logic [8:0]  en;
      int          due;
   } wr_t;

   typedef struct {
      int         beat;
      logic [6:0] w;
      logic [2:0] h;
      logic [8:0] en;
   } vec_t;

   localparam int NT = 14;
   vec_t tbl[NT];

   wr_t  wq[$];
   int   n_cmp, n_bad, cyc;
   int   wr_pulses, rd_cnt, done_cnt, last_wr_cyc, last_rd_cyc, obs_n;
   logic [6:0] obs_w[80];
   logic [2:0] obs_h[80];
   logic [8:0] obs_en[80];
   logic [7:0] cfg_exp;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic wr_t exp_write(input int i, input logic [71:0] d);
      wr_t e;
      int  k;
      e.due = 0;
      e.d   = d;
      if (i < 8) begin
         e.w = 7'd80; e.h = 3'(i); e.d = {d[15:0], 56'h0}; e.en = 9'h180;
      end else if (i < 16) begin
         e.w = 7'd71; e.h = 3'(i - 8); e.en = 9'h1FF;
      end else begin
         k = i - 16;
         e.w = 7'((k % 8) * 9); e.h = 3'(k / 8);
         e.en = ((k % 8) == 7) ? 9'h1FE : 9'h1FF;
      end
      return e;
   endfunction

   task automatic monitor();
      wr_t e;
      logic [62:0] ew;
      logic [26:0] eh;
      if (en_in != 9'h0) begin
         wr_pulses++;
         if (wq.size() == 0) begin
            chk("unexpected_write", 128'(en_in), 128'(0));
         end else begin
            e = wq.pop_front();
            chk("wr_cycle", 128'(cyc), 128'(e.due));
            chk("write_w", 128'(write_w), 128'(e.w));
            chk("write_h", 128'(write_h), 128'(e.h));
            chk("data_in", 128'(data_in), 128'(e.d));
            chk("en_in", 128'(en_in), 128'(e.en));
         end
         if (obs_n < 80) begin
            obs_w[obs_n] = write_w; obs_h[obs_n] = write_h; obs_en[obs_n] = en_in;
         end
         obs_n++;
         last_wr_cyc = cyc;
      end
      if (en_read != 9'h0) begin
         for (int k = 0; k < 9; k++) begin
            ew[(8-k)*7 +: 7] = 7'((rd_cnt % 8) * 9 + k);
            eh[(8-k)*3 +: 3] = 3'(rd_cnt / 8);
         end
         chk("readi_w", 128'(readi_w), 128'(ew));
         chk("readi_h", 128'(readi_h), 128'(eh));
         chk("step", 128'(step), 128'(rd_cnt % 8));
         chk("rd_enables", 128'({en_read, en_bias, en_pe}), 128'({9'h1FF, 1'b1, 1'b1}));
         chk("rd_cycle", 128'(cyc), 128'(last_wr_cyc + 1 + rd_cnt));
         if (rd_cnt == 17) begin
            chk("rd_r2c1_w", 128'(readi_w),
                128'({7'd9, 7'd10, 7'd11, 7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17}));
            chk("rd_r2c1_h", 128'(readi_h), 128'({9{3'd2}}));
            chk("rd_r2c1_step", 128'(step), 128'(1));
         end
         rd_cnt++;
         last_rd_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         chk("done_after_rd", 128'(cyc), 128'(last_rd_cyc + 1));
         chk("done_rd_beats", 128'(rd_cnt), 128'(64));
         chk("done_busy_low", 128'(busy), 128'(0));
         chk("done_rd_off", 128'(en_read), 128'(0));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   task automatic do_start(input logic [7:0] cfg);
      wq.delete();
      rd_cnt = 0; wr_pulses = 0; obs_n = 0;
      {cfg_bound_level, cfg_step_p, cfg_relu, cfg_mp} = cfg;
      cfg_exp = cfg;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 128'(busy), 128'(1));
      chk("cfg_latched", 128'({bound_level, step_p, en_relu, en_mp}), 128'(cfg));
      {cfg_bound_level, cfg_step_p, cfg_relu, cfg_mp} = ~cfg;
   endtask

   task automatic send_beat(input int idx, input bit gap, input bit pulse_start);
      logic [95:0] r96;
      wr_t e;
      if (gap) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         s_valid = 1'b0; s_data = r96[71:0];
         if (pulse_start) start = 1'b1;
         tick();
         start = 1'b0;
      end
      r96 = {$urandom(), $urandom(), $urandom()};
      s_valid = 1'b1; s_data = r96[71:0];
      #1;
      chk("s_ready", 128'(s_ready), 128'(1));
      e = exp_write(idx, s_data);
      e.due = cyc + 1;
      wq.push_back(e);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic run_loads(input int n, input bit toggle, input int start_at);
      for (int i = 0; i < n; i++) send_beat(i, toggle, i == start_at);
   endtask

   task automatic wait_done();
      int d0;
      d0 = done_cnt;
      s_valid = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (done_cnt != d0) break;
         tick();
      end
      chk("done_seen", 128'(done_cnt), 128'(d0 + 1));
      for (int k = 0; k < 3; k++) tick();
      chk("done_once", 128'(done_cnt), 128'(d0 + 1));
      chk("wr_pulses", 128'(wr_pulses), 128'(80));
      chk("idle_ready", 128'(s_ready), 128'(0));
      chk("cfg_hold", 128'({bound_level, step_p, en_relu, en_mp}), 128'(cfg_exp));
   endtask

   initial begin
      tbl[0]  = '{0,  7'd80, 3'd0, 9'h180};
      tbl[1]  = '{3,  7'd80, 3'd3, 9'h180};
      tbl[2]  = '{7,  7'd80, 3'd7, 9'h180};
      tbl[3]  = '{8,  7'd71, 3'd0, 9'h1FF};
      tbl[4]  = '{15, 7'd71, 3'd7, 9'h1FF};
      tbl[5]  = '{40, 7'd0,  3'd3, 9'h1FF};
      tbl[6]  = '{41, 7'd9,  3'd3, 9'h1FF};
      tbl[7]  = '{42, 7'd18, 3'd3, 9'h1FF};
      tbl[8]  = '{43, 7'd27, 3'd3, 9'h1FF};
      tbl[9]  = '{44, 7'd36, 3'd3, 9'h1FF};
      tbl[10] = '{45, 7'd45, 3'd3, 9'h1FF};
      tbl[11] = '{46, 7'd54, 3'd3, 9'h1FF};
      tbl[12] = '{47, 7'd63, 3'd3, 9'h1FE};
      tbl[13] = '{79, 7'd63, 3'd7, 9'h1FE};

      n_cmp = 0; n_bad = 0; cyc = 0;
      wr_pulses = 0; rd_cnt = 0; done_cnt = 0; last_wr_cyc = 0; last_rd_cyc = 0; obs_n = 0;
      start = 0; abort = 0; s_valid = 0; s_data = '0;
      {cfg_bound_level, cfg_step_p, cfg_relu, cfg_mp} = 8'h0;
      reset = 1'b1;
      #3 reset = 1'b0;
      tick(); tick();
      chk("reset_wr_side", 128'({s_ready, busy, done, write_w, write_h, data_in, en_in}), 128'(0));
      chk("reset_rd_side", 128'({readi_w, readi_h, en_read, en_bias, step, en_pe,
                                 bound_level, step_p, en_relu, en_mp}), 128'(0));
      reset = 1'b1;
      tick();

      // Tile A: s_valid held high
      do_start(8'hA5);
      run_loads(80, 1'b0, -1);
      wait_done();
      for (int i = 0; i < NT; i++) begin
         chk("tbl_write_w", 128'(obs_w[tbl[i].beat]), 128'(tbl[i].w));
         chk("tbl_write_h", 128'(obs_h[tbl[i].beat]), 128'(tbl[i].h));
         chk("tbl_en_in", 128'(obs_en[tbl[i].beat]), 128'(tbl[i].en));
      end

      // Tile B: s_valid every other cycle, stray start while busy
      do_start(8'h5A);
      run_loads(80, 1'b1, 30);
      wait_done();

      // Tile C: abort at input row 4, group 2
      do_start(8'h3C);
      run_loads(50, 1'b0, -1);
      begin
         int d0;
         logic [95:0] r96;
         d0 = done_cnt;
         r96 = {$urandom(), $urandom(), $urandom()};
         s_valid = 1'b1; s_data = r96[71:0]; abort = 1'b1;
         #1;
         chk("abort_not_ready", 128'(s_ready), 128'(0));
         tick();
         abort = 1'b0;
         chk("abort_busy", 128'(busy), 128'(0));
         chk("abort_en_in", 128'(en_in), 128'(0));
         chk("abort_idle_ready", 128'(s_ready), 128'(0));
         chk("abort_q_empty", 128'(wq.size()), 128'(0));
         for (int k = 0; k < 4; k++) tick();
         s_valid = 1'b0;
         chk("abort_no_done", 128'(done_cnt), 128'(d0));
         chk("abort_wr_pulses", 128'(wr_pulses), 128'(50));
      end

      // Tile D: restart from bias row 0, then async reset mid-sweep
      do_start(8'hC3);
      run_loads(80, 1'b0, -1);
      s_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (rd_cnt >= 10) break;
         start = (rd_cnt == 4);
         tick();
      end
      start = 1'b0;
      chk("rd_reached", 128'(rd_cnt), 128'(10));
      #2 reset = 1'b0;
      #1;
      chk("async_rst_wr", 128'({s_ready, busy, done, write_w, write_h, data_in, en_in}), 128'(0));
      chk("async_rst_rd", 128'({readi_w, readi_h, en_read, en_bias, step, en_pe,
                                bound_level, step_p, en_relu, en_mp}), 128'(0));
      begin
         int d0;
         d0 = done_cnt;
         tick(); tick();
         reset = 1'b1;
         for (int k = 0; k < 3; k++) tick();
         chk("post_rst_busy", 128'(busy), 128'(0));
         chk("post_rst_ready", 128'(s_ready), 128'(0));
         chk("post_rst_no_done", 128'(done_cnt), 128'(d0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
